// File: rtl/weightbuffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : weightbuffer_pkg
// Purpose  : Shared types and helpers for the multiset weight buffer.
// Revision : 1.0 - initial release
// ============================================================================
package weightbuffer_pkg;

    localparam int N_I_DEF    = 512;
    localparam int K_DEF      = 3;
    localparam int N_SETS_DEF = 4;

    // Bits in one stored K x K x N_I ternary weight set (2 bits per weight)
    function automatic int set_width(input int k, input int n_i);
        return k * k * n_i * 2;
    endfunction

    typedef logic [0:K_DEF-1][0:K_DEF-1][0:N_I_DEF-1][1:0] wset_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/weightbuffer_multiset_if.sv
`default_nettype none
// ============================================================================
// Module   : weightbuffer_multiset_if
// Purpose  : Loader / compute-side bus of the multiset weight buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface weightbuffer_multiset_if #(
    parameter int N_I    = 512,
    parameter int K      = 3,
    parameter int N_SETS = 4
);
    logic [0:K-1][0:K-1][0:N_I-1][1:0] data_i;
    logic                              save_valid_i;
    logic                              save_ready_o;
    logic                              rd_en_i;
    logic [0:K-1][0:K-1][0:N_I-1][1:0] data_o;
    logic                              data_valid_o;
    logic                              release_i;
    logic                              set_avail_o;
    logic [$clog2(N_SETS+1)-1:0]       fill_count_o;
    logic                              flush_i;
    logic                              flush_busy_o;

    modport master (
        output data_i, save_valid_i, rd_en_i, release_i, flush_i,
        input  save_ready_o, data_o, data_valid_o, set_avail_o, fill_count_o, flush_busy_o
    );

    modport slave (
        input  data_i, save_valid_i, rd_en_i, release_i, flush_i,
        output save_ready_o, data_o, data_valid_o, set_avail_o, fill_count_o, flush_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/weightbuffer_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : weightbuffer_sdp_ram
// Purpose  : Simple-dual-port RAM, registered read, unreset array (BRAM).
// Revision : 1.0 - initial release
// ============================================================================
module weightbuffer_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_ni,
    input  wire logic                     we_i,
    input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic                     re_i,
    input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic      [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset so the array itself still maps to BRAM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= r_mem[raddr_i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/weightbuffer_multiset.sv
`default_nettype none
// ============================================================================
// Module   : weightbuffer_multiset
// Purpose  : N_SETS-deep circular weight-set buffer with multi-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module weightbuffer_multiset
    import weightbuffer_pkg::*;
#(
    parameter int N_I    = 512,
    parameter int K      = 3,
    parameter int N_SETS = 4
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    weightbuffer_multiset_if.slave bus
);
    localparam int W     = set_width(K, N_I);
    localparam int PTR_W = $clog2(N_SETS);
    localparam int CNT_W = $clog2(N_SETS + 1);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(N_SETS - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(N_SETS);

    state_t           r_state, w_state_nxt;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_flush_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_data_valid;

    logic             w_save_ready, w_flush_start, w_save_fire, w_rd_fire, w_rel_fire;
    logic             w_in_flush, w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [W-1:0]     w_wdata, w_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.flush_i)            w_state_nxt = FLUSH;
            FLUSH:   if (r_flush_cnt == C_LAST)  w_state_nxt = IDLE;
            default:                             w_state_nxt = IDLE;
        endcase
    end

    // Flush wins over every other request raised in the same idle cycle
    always_comb begin
        w_in_flush    = (r_state == FLUSH);
        w_save_ready  = (r_state == IDLE) && (r_count < C_FULL);
        w_flush_start = (r_state == IDLE) && bus.flush_i;
        w_save_fire   = w_save_ready && bus.save_valid_i && !bus.flush_i;
        w_rd_fire     = (r_state == IDLE) && !bus.flush_i && bus.rd_en_i   && (r_count != '0);
        w_rel_fire    = (r_state == IDLE) && !bus.flush_i && bus.release_i && (r_count != '0);
        w_we          = w_in_flush || w_save_fire;
        w_waddr       = w_in_flush ? r_flush_cnt : r_wr_ptr;
        w_wdata       = w_in_flush ? '0 : W'(bus.data_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_flush_cnt  <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_fire;
            if (w_flush_start) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_flush_cnt <= '0;
            end else if (w_in_flush) begin
                r_flush_cnt <= ptr_inc(r_flush_cnt);
            end else begin
                if (w_save_fire) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_rel_fire)  r_rd_ptr <= ptr_inc(r_rd_ptr);
                case ({w_save_fire, w_rel_fire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    weightbuffer_sdp_ram #(
        .WIDTH (W),
        .DEPTH (N_SETS)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .re_i    (w_rd_fire),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_rdata)
    );

    assign bus.data_o       = w_rdata;
    assign bus.data_valid_o = r_data_valid;
    assign bus.save_ready_o = w_save_ready;
    assign bus.set_avail_o  = (r_count != '0);
    assign bus.fill_count_o = r_count;
    assign bus.flush_busy_o = w_in_flush;
endmodule
`default_nettype wire
